memory_param_rmw: RTL and testbench
===================================

// Module: memory_param_rmw
// PURPOSE
//  Parametrised, multi-cycle successor to the 16x8 CPU data memory. It sits between central_processing_unit and its packed memory bus.
//  Width and depth are generic. It adds a registered read with a valid strobe and in-place increment/decrement (read-modify-write).
//  It also adds a full-array CLEAR sweep and a busy flag that the CPU samples before issuing commands.
// PARAMETERS
//  DATA_W      8    data word width (bits)
//  ADDR_W      4    address width (bits)
//  DEPTH       16   number of words, 1 <= DEPTH <= 2**ADDR_W
//  INIT_SWEEP  1    1: reset launches a CLEAR sweep; 0: reset leaves array contents undefined
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       asynchronous, active-high reset
//  data_in   in   DATA_W  write data
//  address   in   ADDR_W  word address
//  ctrl      in   3       command opcode
//  data_out  out  DATA_W  registered read/RMW result
//  valid     out  1       one-cycle strobe: data_out updated this cycle
//  busy      out  1       1 = commands are ignored
// BEHAVIOUR
//  Reset is async, active-high and one clock domain only (clk). Reset values are:
//   data_out=0, valid=0, cnt=0.
//   If INIT_SWEEP=1: state=SWEEP, busy=1.
//   If INIT_SWEEP=0: state=IDLE, busy=0.
//  Reset asserted mid-RMW or mid-SWEEP aborts that operation. A partial RMW never writes.
//  Opcodes are sampled at posedge only when state==IDLE; while busy, ctrl is ignored and not queued.
//   000 NOP.
//   001 READ: data_out<=mem[address], valid=1 on the next cycle. Latency 1.
//   010 WRITE: mem[address]<=data_in. data_out is held; valid=0.
//   011 INC / 100 DEC: 2 cycles, with address latched in cycle 0.
//    Cycle 0: IDLE->RMW, busy=1.
//    Cycle 1: mem<=mem+/-1, mod 2**DATA_W (0xFF+1->0x00, 0x00-1->0xFF). data_out=new value, valid=1, RMW->IDLE.
//   101 CLEAR: IDLE->SWEEP, busy=1. One zero is written per cycle at cnt=0..DEPTH-1.
//    busy drops in the cycle after the cnt=DEPTH-1 write. Total busy = DEPTH cycles.
//   110/111 are reserved and behave as NOP.
//  valid is 0 in every cycle not listed above and never stays high for 2 consecutive cycles from one command.
//  Out-of-range address (address >= DEPTH):
//   WRITE/INC/DEC have no effect on the array.
//   READ returns 0 with valid=1.
//   INC/DEC still take 2 cycles and return 0 with valid=1.
//  Back-to-back commands:
//   WRITE then READ of the same address on the next cycle returns the new data (no stale read).
//   A READ issued in the cycle busy falls returns post-operation contents.
//  busy is a registered output: busy = (state != IDLE).
//  FSM:
//   IDLE  -INC/DEC->  RMW
//   IDLE  -CLEAR->    SWEEP
//   RMW   -always->   IDLE
//   SWEEP -cnt==DEPTH-1-> IDLE
// STRUCTURE
//  memory_pkg holds:
//   opcode localparams OP_NOP..OP_CLEAR.
//   FSM state encodings ST_IDLE, ST_RMW, ST_SWEEP (2 bits).
//  Sub-module sweep_counter is an ADDR_W-bit up-counter with async reset, start and done (done at DEPTH-1).
//  The array is a DEPTH x DATA_W reg with one write port. Write-port mux priority: SWEEP > RMW > WRITE.
// TESTING
//  1. Reset, INIT_SWEEP=1, DEPTH=16 -> busy=1 for 16 cycles, then 0. A READ of every address returns 0x00 with valid pulsed 1 cycle each.
//  2. WRITE addr3=0xA5, READ addr3 on the next cycle -> data_out=0xA5, valid=1 exactly 1 cycle later. WRITE does not pulse valid.
//  3. WRITE addr7=0xFF, INC addr7 -> busy=1 for 1 cycle, then data_out=0x00, valid=1. A READ then gives 0x00.
//     DEC on 0x00 -> 0xFF.
//  4. WRITE 0x11 issued while busy (during CLEAR) -> ignored. After the sweep, that address reads 0x00.
//  5. Assert reset in cycle 5 of a CLEAR:
//     - busy restarts and lasts a full DEPTH cycles (INIT_SWEEP=1).
//     - outputs are 0 while reset is high.
//  6. DEPTH=12, ADDR_W=4:
//     - WRITE addr14=0x5A leaves addr0..11 unchanged.
//     - READ addr14 -> 0x00, valid=1.
//     - CLEAR busy = 12 cycles.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared opcodes and FSM state encodings for the parametrised RMW data memory.
package memory_pkg;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_READ  = 3'b001;
   localparam logic [2:0] OP_WRITE = 3'b010;
   localparam logic [2:0] OP_INC   = 3'b011;
   localparam logic [2:0] OP_DEC   = 3'b100;
   localparam logic [2:0] OP_CLEAR = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RMW   = 2'b01,
      ST_SWEEP = 2'b10
   } state_t;

endpackage

// File: rtl/sweep_counter.sv
// Address counter for the CLEAR sweep: walks 0..DEPTH-1 and flags the last word.
module sweep_counter #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              en,
   output logic [ADDR_W-1:0] cnt,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   assign done = (cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= done ? '0 : cnt + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/memory_param_rmw.sv
// Parametrised data memory with registered read, in-place INC/DEC and a full-array CLEAR sweep.
module memory_param_rmw
   import memory_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 4,
   parameter int DEPTH      = 16,
   parameter bit INIT_SWEEP = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] address,
   input  logic [2:0]        ctrl,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              busy
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   logic [ADDR_W-1:0] rmw_addr;
   logic              rmw_inc;
   logic [ADDR_W-1:0] cnt;
   logic              sweep_done;
   logic              in_range;
   logic              rmw_in_range;
   logic [DATA_W-1:0] rmw_old;
   logic [DATA_W-1:0] rmw_val;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   assign in_range     = ({1'b0, address}  < DEPTH_L);
   assign rmw_in_range = ({1'b0, rmw_addr} < DEPTH_L);
   assign rmw_old      = mem[rmw_addr];
   assign rmw_val      = rmw_inc ? rmw_old + DATA_W'(1) : rmw_old - DATA_W'(1);

   sweep_counter #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_sweep (
      .clk   (clk),
      .reset (reset),
      .start (state == ST_IDLE && ctrl == OP_CLEAR),
      .en    (state == ST_SWEEP),
      .cnt   (cnt),
      .done  (sweep_done)
   );

   // Single write port; the sweep wins over a pending RMW, which wins over a plain WRITE.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      we    = 1'b0;
      waddr = address;
      wdata = data_in;
      if (!reset) begin
         if (state == ST_SWEEP) begin
            we    = 1'b1;
            waddr = cnt;
            wdata = '0;
         end else if (state == ST_RMW) begin
            we    = rmw_in_range;
            waddr = rmw_addr;
            wdata = rmw_val;
         end else if (state == ST_IDLE && ctrl == OP_WRITE) begin
            we    = in_range;
         end
      end
   end

   // NOTE: the array has no reset; initialisation is the job of the CLEAR sweep, which keeps it RAM-inferable.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= INIT_SWEEP ? ST_SWEEP : ST_IDLE;
         busy     <= INIT_SWEEP;
         data_out <= '0;
         valid    <= 1'b0;
         rmw_addr <= '0;
         rmw_inc  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               case (ctrl)
                  OP_READ: begin
                     data_out <= in_range ? mem[address] : '0;
                     valid    <= 1'b1;
                  end
                  OP_INC, OP_DEC: begin
                     state    <= ST_RMW;
                     busy     <= 1'b1;
                     rmw_addr <= address;
                     rmw_inc  <= (ctrl == OP_INC);
                  end
                  OP_CLEAR: begin
                     state <= ST_SWEEP;
                     busy  <= 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_RMW: begin
               data_out <= rmw_in_range ? rmw_val : '0;
               valid    <= 1'b1;
               state    <= ST_IDLE;
               busy     <= 1'b0;
            end
            ST_SWEEP: begin
               if (sweep_done) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_param_rmw.sv
// Directed bench for memory_param_rmw: a DEPTH=16 instance and a DEPTH=12 instance on one clock.
module tb_memory_param_rmw;
   import memory_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in,  data_in12;
   logic [3:0] address,  address12;
   logic [2:0] ctrl,     ctrl12;
   logic [7:0] data_out, data_out12;
   logic       valid,    valid12;
   logic       busy,     busy12;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [2:0] ctrl;
      logic [3:0] addr;
      logic [7:0] din;
      logic [7:0] exp_dout;
      logic       exp_valid;
      logic       exp_busy;
   } vec_t;

   vec_t vecs [22];

   always #5 clk = ~clk;

   memory_param_rmw #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_SWEEP(1'b1)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .address(address), .ctrl(ctrl),
      .data_out(data_out), .valid(valid), .busy(busy)
   );

   memory_param_rmw #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_SWEEP(1'b1)) dut12 (
      .clk(clk), .reset(reset), .data_in(data_in12), .address(address12), .ctrl(ctrl12),
      .data_out(data_out12), .valid(valid12), .busy(busy12)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [2:0] c, input logic [3:0] a, input logic [7:0] d);
      ctrl = c; address = a; data_in = d;
      tick();
   endtask

   task automatic apply12(input logic [2:0] c, input logic [3:0] a, input logic [7:0] d);
      ctrl12 = c; address12 = a; data_in12 = d;
      tick();
   endtask

   // Counts edges while busy is high; the loop bound turns a stuck busy into a failed count.
   task automatic count_busy(output int n16, output int n12);
      logic b16, b12;
      n16 = 0; n12 = 0;
      for (int c = 0; c < 100 && (busy || busy12); c++) begin
         b16 = busy; b12 = busy12;
         tick();
         if (b16) n16++;
         if (b12) n12++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n16, n12;

      vecs[0]  = '{OP_WRITE, 4'd3,  8'hA5, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{OP_READ,  4'd3,  8'h00, 8'hA5, 1'b1, 1'b0};
      vecs[2]  = '{OP_NOP,   4'd3,  8'h00, 8'hA5, 1'b0, 1'b0};
      vecs[3]  = '{OP_WRITE, 4'd7,  8'hFF, 8'hA5, 1'b0, 1'b0};
      vecs[4]  = '{OP_INC,   4'd7,  8'h00, 8'hA5, 1'b0, 1'b1};
      vecs[5]  = '{OP_NOP,   4'd7,  8'h00, 8'h00, 1'b1, 1'b0};
      vecs[6]  = '{OP_READ,  4'd7,  8'h00, 8'h00, 1'b1, 1'b0};
      vecs[7]  = '{OP_DEC,   4'd7,  8'h00, 8'h00, 1'b0, 1'b1};
      vecs[8]  = '{OP_NOP,   4'd7,  8'h00, 8'hFF, 1'b1, 1'b0};
      vecs[9]  = '{OP_READ,  4'd7,  8'h00, 8'hFF, 1'b1, 1'b0};
      vecs[10] = '{OP_INC,   4'd3,  8'h00, 8'hFF, 1'b0, 1'b1};
      vecs[11] = '{OP_READ,  4'd0,  8'h00, 8'hA6, 1'b1, 1'b0};
      vecs[12] = '{OP_READ,  4'd3,  8'h00, 8'hA6, 1'b1, 1'b0};
      vecs[13] = '{3'b110,   4'd3,  8'h77, 8'hA6, 1'b0, 1'b0};
      vecs[14] = '{3'b111,   4'd3,  8'h77, 8'hA6, 1'b0, 1'b0};
      vecs[15] = '{OP_READ,  4'd3,  8'h00, 8'hA6, 1'b1, 1'b0};
      vecs[16] = '{OP_WRITE, 4'd0,  8'h3C, 8'hA6, 1'b0, 1'b0};
      vecs[17] = '{OP_WRITE, 4'd0,  8'h3D, 8'hA6, 1'b0, 1'b0};
      vecs[18] = '{OP_READ,  4'd0,  8'h00, 8'h3D, 1'b1, 1'b0};
      vecs[19] = '{OP_DEC,   4'd0,  8'h00, 8'h3D, 1'b0, 1'b1};
      vecs[20] = '{OP_DEC,   4'd0,  8'h00, 8'h3C, 1'b1, 1'b0};
      vecs[21] = '{OP_READ,  4'd0,  8'h00, 8'h3C, 1'b1, 1'b0};

      ctrl = OP_NOP; address = '0; data_in = '0;
      ctrl12 = OP_NOP; address12 = '0; data_in12 = '0;
      reset = 1'b1;
      tick();
      tick();
      check("rst_busy", busy, 1'b1);
      check("rst_dout", data_out, 8'h00);
      check("rst_valid", valid, 1'b0);
      check("rst_busy12", busy12, 1'b1);

      // Reset sweep lengths for both depths.
      reset = 1'b0;
      count_busy(n16, n12);
      check("init_sweep_len", n16, 16);
      check("init_sweep_len12", n12, 12);

      for (int i = 0; i < 16; i++) begin
         apply(OP_READ, 4'(i), 8'h00);
         check($sformatf("init_rd%0d_dout", i), data_out, 8'h00);
         check($sformatf("init_rd%0d_valid", i), valid, 1'b1);
      end
      apply(OP_NOP, 4'd0, 8'h00);
      check("init_rd_valid_drop", valid, 1'b0);

      for (int i = 0; i < 22; i++) begin
         apply(vecs[i].ctrl, vecs[i].addr, vecs[i].din);
         check($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
         check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      end

      // WRITE issued during a CLEAR is dropped; READ in the cycle busy falls sees cleared data.
      apply(OP_CLEAR, 4'd0, 8'h00);
      check("clr_busy_rise", busy, 1'b1);
      apply(OP_WRITE, 4'd5, 8'h11);
      ctrl = OP_NOP;
      count_busy(n16, n12);
      check("clr_len", n16 + 1, 16);
      apply(OP_READ, 4'd5, 8'h00);
      check("clr_rd5_dout", data_out, 8'h00);
      check("clr_rd5_valid", valid, 1'b1);
      apply(OP_READ, 4'd7, 8'h00);
      check("clr_rd7_dout", data_out, 8'h00);

      // Reset in cycle 5 of a CLEAR restarts a full-length sweep.
      apply(OP_WRITE, 4'd2, 8'h42);
      apply(OP_READ, 4'd2, 8'h00);
      check("pre_rst_dout", data_out, 8'h42);
      apply(OP_CLEAR, 4'd0, 8'h00);
      ctrl = OP_NOP;
      for (int i = 0; i < 4; i++) tick();
      check("mid_clr_busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_dout", data_out, 8'h00);
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_busy", busy, 1'b1);
      tick();
      check("mid_rst_dout_hold", data_out, 8'h00);
      reset = 1'b0;
      count_busy(n16, n12);
      check("rst_sweep_len", n16, 16);
      check("rst_sweep_len12", n12, 12);
      apply(OP_READ, 4'd2, 8'h00);
      check("post_rst_rd2", data_out, 8'h00);

      // DEPTH=12: out-of-range writes, reads and RMW leave the array alone and return zero.
      for (int i = 0; i < 12; i++) apply12(OP_WRITE, 4'(i), 8'h10 + 8'(i));
      apply12(OP_WRITE, 4'd14, 8'h5A);
      apply12(OP_WRITE, 4'd12, 8'h66);
      for (int i = 0; i < 12; i++) begin
         apply12(OP_READ, 4'(i), 8'h00);
         check($sformatf("d12_rd%0d", i), data_out12, 8'h10 + 8'(i));
      end
      apply12(OP_READ, 4'd14, 8'h00);
      check("d12_rd14_dout", data_out12, 8'h00);
      check("d12_rd14_valid", valid12, 1'b1);
      apply12(OP_READ, 4'd12, 8'h00);
      check("d12_rd12_dout", data_out12, 8'h00);
      apply12(OP_INC, 4'd14, 8'h00);
      check("d12_inc14_busy", busy12, 1'b1);
      apply12(OP_NOP, 4'd0, 8'h00);
      check("d12_inc14_dout", data_out12, 8'h00);
      check("d12_inc14_valid", valid12, 1'b1);
      apply12(OP_READ, 4'd11, 8'h00);
      check("d12_rd11_after", data_out12, 8'h1B);
      apply12(OP_CLEAR, 4'd0, 8'h00);
      ctrl12 = OP_NOP;
      count_busy(n16, n12);
      check("d12_clr_len", n12, 12);
      apply12(OP_READ, 4'd11, 8'h00);
      check("d12_clr_rd11", data_out12, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
